// File: rtl/pll_dps_pkg.sv
// Shared types and constants for the PLL dynamic-phase-shift sequencer.
package pll_dps_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      EN,
      WAIT_LO,
      WAIT_HI,
      GAP
   } state_t;

   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_LOCK    = 1;
   localparam int CNTSEL_W    = 5;

endpackage

// File: rtl/pll_dps_ctrl_if.sv
// Shift-request channel between capture-alignment logic and the DPS sequencer.
interface pll_dps_ctrl_if #(
   parameter int CNT_W  = 1,
   parameter int STEP_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [CNT_W-1:0]  req_cnt;
   logic              req_updn;
   logic [STEP_W-1:0] req_steps;
   logic              done;
   logic [1:0]        err;

   modport master (output req_valid, req_cnt, req_updn, req_steps,
                   input  req_ready, done, err);
   modport slave  (input  req_valid, req_cnt, req_updn, req_steps,
                   output req_ready, done, err);
endinterface

// File: rtl/pll_dps_pos_mod.sv
// Phase position of one PLL output counter, wrapping modulo one output period.
module pll_dps_pos_mod #(
   parameter int POS_W   = 8,
   parameter int MODULUS = 24
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [POS_W-1:0] pos
);
   localparam logic [POS_W:0] TOP = (POS_W+1)'(MODULUS - 1);

   logic [POS_W:0] wide;

   // One extra bit keeps pos+1 from wrapping before the modulus compare.
   always_comb begin
      wide = {1'b0, pos};
      if (inc)
         wide = (wide == TOP) ? '0 : wide + 1'b1;
      else if (dec)
         wide = (wide == '0) ? TOP : wide - 1'b1;
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) pos <= '0;
      else     pos <= wide[POS_W-1:0];
   end
endmodule

// File: rtl/pll_dps_ctrl.sv
// PLL DPS sequencer: splits multi-step shift requests into single-step phase_en
// handshakes and tracks per-counter phase. PLL_DPS_HOME_EN adds return-to-zero homing.
//
// state   | meaning
// IDLE    | ready for a request (or home command)
// CHECK   | reject zero-step, bad-index or unlocked requests
// EN      | phase_en high for EN_CYCLES cycles
// WAIT_LO | waiting for synced phase_done to fall
// WAIT_HI | waiting for synced phase_done to rise; step completes here
// GAP     | one spacer cycle before the next step
module pll_dps_ctrl
   import pll_dps_pkg::*;
#(
   parameter int NUM_CNT          = 1,
   parameter int STEP_W           = 8,
   parameter int POS_W            = 8,
   parameter int STEPS_PER_PERIOD = 24,
   parameter int EN_CYCLES        = 2,
   parameter int TIMEOUT          = 1023,
   localparam int CNT_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
   input  logic                     refclk,
   input  logic                     rst,
   pll_dps_ctrl_if.slave            req,
   output logic                     busy,
   output logic [NUM_CNT*POS_W-1:0] pos,
   output logic                     phase_en,
   output logic                     updn,
   output logic [CNTSEL_W-1:0]      cntsel,
   input  logic                     phase_done,
   input  logic                     locked
`ifdef PLL_DPS_HOME_EN
   ,
   input  logic                     home_req,
   input  logic [CNT_W-1:0]         home_cnt
`endif
);
   localparam int TMR_MAX = (TIMEOUT > EN_CYCLES) ? TIMEOUT : EN_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   if (STEPS_PER_PERIOD > 2**POS_W || NUM_CNT < 1 || NUM_CNT > 18) begin : g_param_chk
      $error("pll_dps_ctrl: STEPS_PER_PERIOD must fit POS_W and NUM_CNT must be 1..18");
   end

   state_t            state, state_nxt;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              updn_q, updn_nxt;
   logic [STEP_W-1:0] steps_q, steps_nxt;
   logic [1:0]        err_q, err_nxt;
   logic              done_q, done_nxt;
   logic              step_ok;
   logic [1:0]        pd_sync, lk_sync;
   logic              pd_s, lk_s, cnt_bad;
   logic [NUM_CNT-1:0] inc_v, dec_v;

   assign pd_s    = pd_sync[1];
   assign lk_s    = lk_sync[1];
   assign cnt_bad = ({1'b0, cnt_q} >= (CNT_W+1)'(NUM_CNT));

`ifdef PLL_DPS_HOME_EN
   logic [POS_W-1:0] home_pos;

   always_comb begin
      home_pos = '0;
      for (int k = 0; k < NUM_CNT; k++)
         if (home_cnt == CNT_W'(k)) home_pos = pos[k*POS_W +: POS_W];
   end
`endif

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      cnt_nxt   = cnt_q;
      updn_nxt  = updn_q;
      steps_nxt = steps_q;
      err_nxt   = err_q;
      done_nxt  = 1'b0;
      step_ok   = 1'b0;
      case (state)
         IDLE: begin
            if (!done_q) begin
`ifdef PLL_DPS_HOME_EN
               if (home_req) begin
                  cnt_nxt   = home_cnt;
                  err_nxt   = '0;
                  state_nxt = CHECK;
                  // Shortest way back to zero; a half-period tie goes down.
                  if (int'(home_pos) > STEPS_PER_PERIOD / 2) begin
                     updn_nxt  = 1'b1;
                     steps_nxt = STEP_W'(STEPS_PER_PERIOD - int'(home_pos));
                  end else begin
                     updn_nxt  = 1'b0;
                     steps_nxt = STEP_W'(home_pos);
                  end
               end else
`endif
               if (req.req_valid) begin
                  cnt_nxt   = req.req_cnt;
                  updn_nxt  = req.req_updn;
                  steps_nxt = req.req_steps;
                  err_nxt   = '0;
                  state_nxt = CHECK;
               end
            end
         end
         CHECK: begin
            if (steps_q == '0) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (cnt_bad) begin
               err_nxt[ERR_LOCK] = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = TMR_W'(EN_CYCLES - 1);
               state_nxt = EN;
            end
         end
         EN: begin
            if (timer == '0) begin
               timer_nxt = TMR_W'(TIMEOUT - 1);
               state_nxt = WAIT_LO;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         WAIT_LO: begin
            if (!pd_s) begin
               timer_nxt = TMR_W'(TIMEOUT - 1);
               state_nxt = WAIT_HI;
            end else if (timer == '0) begin
               err_nxt[ERR_TIMEOUT] = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         WAIT_HI: begin
            if (pd_s) begin
               step_ok   = 1'b1;
               steps_nxt = steps_q - 1'b1;
               if (steps_q == STEP_W'(1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = GAP;
               end
            end else if (timer == '0) begin
               err_nxt[ERR_TIMEOUT] = 1'b1;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         GAP: begin
            timer_nxt = TMR_W'(EN_CYCLES - 1);
            state_nxt = EN;
         end
         default: state_nxt = IDLE;
      endcase
      // Lock loss aborts from anywhere; steps already completed stay counted.
      if (state != IDLE && !lk_s) begin
         step_ok           = 1'b0;
         steps_nxt         = steps_q;
         err_nxt[ERR_LOCK] = 1'b1;
         done_nxt          = 1'b1;
         state_nxt         = IDLE;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         cnt_q   <= '0;
         updn_q  <= 1'b0;
         steps_q <= '0;
         err_q   <= '0;
         done_q  <= 1'b0;
         pd_sync <= '0;
         lk_sync <= '0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         cnt_q   <= cnt_nxt;
         updn_q  <= updn_nxt;
         steps_q <= steps_nxt;
         err_q   <= err_nxt;
         done_q  <= done_nxt;
         pd_sync <= {pd_sync[0], phase_done};
         lk_sync <= {lk_sync[0], locked};
      end
   end

   // Ready stays low during the done cycle so completion and a new accept never overlap.
   assign req.req_ready = (state == IDLE) && !done_q;
   assign req.done      = done_q;
   assign req.err       = err_q;
   assign busy          = (state != IDLE);
   assign phase_en      = (state == EN) && lk_s;
   assign updn          = updn_q;
   assign cntsel        = CNTSEL_W'(cnt_q);

   for (genvar k = 0; k < NUM_CNT; k++) begin : g_pos
      assign inc_v[k] = step_ok &&  updn_q && (cnt_q == CNT_W'(k));
      assign dec_v[k] = step_ok && !updn_q && (cnt_q == CNT_W'(k));

      pll_dps_pos_mod #(
         .POS_W   (POS_W),
         .MODULUS (STEPS_PER_PERIOD)
      ) u_pos (
         .refclk (refclk),
         .rst    (rst),
         .inc    (inc_v[k]),
         .dec    (dec_v[k]),
         .pos    (pos[k*POS_W +: POS_W])
      );
   end
endmodule
